// File: rtl/reg_bank_if.sv
// Bus bundle for reg_bank: per-register write enables, shared write data,
// and the parallel read-out of every register.
interface reg_bank_if #(
  parameter int NUM_REGS = 32,
  parameter int WIDTH    = 1
);
  logic [NUM_REGS-1:0]            en;
  logic [WIDTH-1:0]               d;
  logic [NUM_REGS-1:0][WIDTH-1:0] q;

  // Master drives enables and data and observes the contents; the bank is the slave.
  modport master (output en, output d, input q);
  modport slave  (input en, input d, output q);
endinterface

// File: rtl/reg_bank.sv
// Storage array for the register-file datapath: NUM_REGS enabled flops of
// WIDTH bits sharing one data input, all contents visible in parallel.
module reg_bank #(
  parameter int NUM_REGS = 32,
  parameter int WIDTH    = 1
) (
  input  logic       clk,
  input  logic       reset,
  reg_bank_if.slave  bus
);

  // One enabled-flop cell per register; en[i] pairs directly with q[i].
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cell
    logic [WIDTH-1:0] r_cell;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_cell <= '0;
      end else if (bus.en[gi]) begin
        r_cell <= bus.d;
      end
    end

    assign bus.q[gi] = r_cell;
  end

endmodule

// File: tb/tb_reg_bank.sv
// Scoreboard bench for reg_bank: driver pushes expected contents from an
// array model, a monitor pops and compares after every rising edge.
module tb_reg_bank;
  localparam int NUM_REGS = 32;
  localparam int WIDTH    = 1;
  localparam int QW       = NUM_REGS * WIDTH;

  logic clk;
  logic reset;

  reg_bank_if #(.NUM_REGS(NUM_REGS), .WIDTH(WIDTH)) bus ();

  reg_bank #(.NUM_REGS(NUM_REGS), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: plain array of register contents
  logic [WIDTH-1:0] model [NUM_REGS];
  logic [QW-1:0]    exp_q [$];
  int               n_checks;
  int               n_fail;

  function automatic logic [QW-1:0] model_vec();
    logic [QW-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REGS; i++) v[i*WIDTH +: WIDTH] = model[i];
    return v;
  endfunction

  task automatic check(input string name, input logic [QW-1:0] act, input logic [QW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
  endtask

  // Drive one cycle at the falling edge and predict q after the next rising edge.
  task automatic step(input logic rst_v, input logic [NUM_REGS-1:0] en_v, input logic [WIDTH-1:0] d_v);
    @(negedge clk);
    reset  = rst_v;
    bus.en = en_v;
    bus.d  = d_v;
    if (!rst_v) begin
      clear_model();
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        if (en_v[i]) model[i] = d_v;
    end
    exp_q.push_back(model_vec());
  endtask

  // monitor
  initial begin
    logic [QW-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("q_after_edge", bus.q, e);
      end
    end
  end

  // stimulus
  initial begin
    logic [NUM_REGS-1:0] ones;
    int                  budget;
    ones     = '1;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    bus.en   = '1;
    bus.d    = '1;
    clear_model();

    #2;
    check("reset_at_start", bus.q, '0);

    // held reset overrides en/d across edges
    repeat (3) step(1'b0, ones, 1'b1);

    // single write then hold
    step(1'b1, 32'h1, 1'b1);
    step(1'b1, '0, 1'b0);

    // broadcast 1 then 0
    step(1'b1, ones, 1'b1);
    step(1'b1, ones, 1'b0);

    // selective hold
    step(1'b1, ones, 1'b1);
    step(1'b1, 32'h8000_0000, 1'b0);

    // walking enable with alternating data
    for (int i = 0; i < NUM_REGS; i++)
      step(1'b1, NUM_REGS'(1) << i, WIDTH'(i % 2 == 0));

    // asynchronous reset between edges
    step(1'b1, ones, 1'b1);
    step(1'b1, '0, 1'b0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    clear_model();
    check("async_reset_clears", bus.q, '0);
    step(1'b0, ones, 1'b1);
    step(1'b1, 32'h20, 1'b1);
    step(1'b1, '0, 1'b0);

    // randomized traffic with occasional reset
    for (int c = 0; c < 300; c++)
      step(($urandom_range(0, 24) != 0), $urandom, WIDTH'($urandom_range(0, 1)));

    step(1'b1, '0, 1'b0);

    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
